// File: rtl/bram_256_8_writer.sv
// bram_256_8_writer
// Sequential loader that fills a 2^ADDR_WIDTH x DATA_WIDTH synchronous RAM
// from a valid/ready byte stream. A start pulse arms a transfer of `count`
// bytes beginning at `base_addr`. Each accepted byte is issued one cycle later
// as a registered write strobe, with the address wrapping modulo the depth.
// A one-cycle `done` pulse marks completion, and `checksum` holds the additive
// sum (mod 2^DATA_WIDTH) of the bytes accepted in the current or last transfer.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   arm a transfer (sampled only in IDLE)
//   base_addr  in   first write address, captured on accepted start
//   count      in   byte count (values above the depth saturate to the depth)
//   abort      in   cancel the transfer in progress (WRITE only)
//   in_valid   in   source has a byte
//   in_data    in   source byte
//   in_ready   out  block accepts a byte this cycle (decoded from state only)
//   wr_en      out  registered RAM write strobe
//   wr_addr    out  registered RAM write address
//   wr_data    out  registered RAM write data
//   busy       out  state is not IDLE
//   done       out  one-cycle completion pulse
//   checksum   out  running byte sum of the current/last transfer
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; checksum of the last transfer is held
// S_WRITE | accepting bytes until remaining reaches zero or abort
// S_DONE  | single-cycle completion pulse, then back to S_IDLE

module bram_256_8_writer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0] cks_q, cks_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [ADDR_WIDTH:0]   count_cap;

    // Any count beyond the RAM depth would only rewrite the same image, so it
    // saturates to one full pass.
    assign count_cap = (count > DEPTH) ? DEPTH : count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            cks_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            cks_q     <= cks_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        cks_d     = cks_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d   = base_addr;
                    rem_d   = count_cap;
                    cks_d   = '0;
                    state_d = (count_cap != '0) ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                // Abort wins over a simultaneous accept: the byte is dropped
                // and neither the RAM nor the checksum sees it.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = in_data;
                    ptr_d     = ptr_q + 1'b1;
                    rem_d     = rem_q - 1'b1;
                    cks_d     = cks_q + in_data;
                    if (rem_q == REM_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == S_WRITE);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign checksum = cks_q;

endmodule
